// File: rtl/uart_cmd_controller.sv
// uart_cmd_controller
//   Pops bytes from the UART rx FIFO one at a time and turns them into snake
//   game commands. Direction keys are held as a pending direction that is
//   committed only on game_tick (and not while paused). A direction that
//   reverses the snake is dropped.
//
//   Optional build macro: UART_CMD_ANSI_ARROWS_EN
//     Defined:     ESC '[' A/B/C/D arrow sequences are decoded as direction keys.
//     Not defined: the ESC and '[' bytes are discarded, and 'A'/'D' are
//                  letter keys.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   rx_empty     in   FIFO empty flag (r_data is valid while low)
//   r_data[7:0]  in   FIFO head byte
//   game_tick    in   one-cycle pulse per snake move
//   rd_uart      out  FIFO pop strobe
//   dir[1:0]     out  committed direction (0 up, 1 right, 2 down, 3 left)
//   pause        out  game paused
//   start_pulse  out  one-cycle start request
//   cmd_strobe   out  one-cycle pulse per accepted recognised byte
//   key_data     out  last accepted recognised byte
//
// state  | meaning
// IDLE   | waiting for a byte in the FIFO
// POP    | pop strobe high, head byte latched
// DECODE | latched byte classified and applied
module uart_cmd_controller #(
  parameter int         LOCK_CYCLES = 1_000_000,
  parameter logic [1:0] INIT_DIR    = 2'd1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  input  logic       game_tick,
  output logic       rd_uart,
  output logic [1:0] dir,
  output logic       pause,
  output logic       start_pulse,
  output logic       cmd_strobe,
  output logic [7:0] key_data
);

  localparam int LW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES);

  typedef enum logic [1:0] {IDLE, POP, DECODE} state_t;

  typedef struct packed {
    logic       valid;
    logic       is_dir;
    logic [1:0] dir;
    logic       space;
    logic       enter;
  } key_t;

  state_t          state, state_nxt;
  logic [7:0]      rx_byte;
  logic [7:0]      last_byte;
  logic [LW-1:0]   lock_cnt;
  logic [1:0]      pending_dir;
  logic            pending_valid;

  key_t            key;
  logic [7:0]      key_byte;
  logic            commit;
  logic [1:0]      ref_dir;
  logic            locked;
  logic            accept;
  logic            relock;

  function automatic key_t decode_plain(input logic [7:0] b);
    key_t k;
    k = '0;
    case (b)
      8'h77, 8'h57: begin k.valid = 1'b1; k.is_dir = 1'b1; k.dir = 2'd0; end
      8'h64, 8'h44: begin k.valid = 1'b1; k.is_dir = 1'b1; k.dir = 2'd1; end
      8'h73, 8'h53: begin k.valid = 1'b1; k.is_dir = 1'b1; k.dir = 2'd2; end
      8'h61, 8'h41: begin k.valid = 1'b1; k.is_dir = 1'b1; k.dir = 2'd3; end
      8'h20:        begin k.valid = 1'b1; k.space = 1'b1; end
      8'h0D:        begin k.valid = 1'b1; k.enter = 1'b1; end
      default:      k = '0;
    endcase
    return k;
  endfunction

  // Control FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_uart   = 1'b0;
    case (state)
      IDLE:   if (!rx_empty) state_nxt = POP;
      POP: begin
        // The FIFO cannot drain on its own, so the gate only matters if the
        // producer side misbehaves; without a byte there is nothing to decode.
        rd_uart   = !rx_empty;
        state_nxt = rx_empty ? IDLE : DECODE;
      end
      DECODE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Byte classification
`ifdef UART_CMD_ANSI_ARROWS_EN
  typedef enum logic [1:0] {ESC_NONE, ESC_1, ESC_2} esc_t;
  esc_t esc_state, esc_nxt;

  always_comb begin
    key      = '0;
    key_byte = rx_byte;
    esc_nxt  = esc_state;
    case (esc_state)
      ESC_NONE: begin
        if (rx_byte == 8'h1B) esc_nxt = ESC_1;
        else                  key = decode_plain(rx_byte);
      end
      ESC_1: esc_nxt = (rx_byte == 8'h5B) ? ESC_2 : ESC_NONE;
      ESC_2: begin
        esc_nxt = ESC_NONE;
        case (rx_byte)
          8'h41: begin key.valid = 1'b1; key.is_dir = 1'b1; key.dir = 2'd0; end
          8'h42: begin key.valid = 1'b1; key.is_dir = 1'b1; key.dir = 2'd2; end
          8'h43: begin key.valid = 1'b1; key.is_dir = 1'b1; key.dir = 2'd1; end
          8'h44: begin key.valid = 1'b1; key.is_dir = 1'b1; key.dir = 2'd3; end
          default: key = '0;
        endcase
      end
      default: esc_nxt = ESC_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                esc_state <= ESC_NONE;
    else if (state == DECODE)  esc_state <= esc_nxt;
  end
`else
  always_comb begin
    key      = decode_plain(rx_byte);
    key_byte = rx_byte;
  end
`endif

  // A tick in the same cycle commits first; new keys are judged against the
  // direction that results from that commit.
  assign commit  = game_tick && !pause && pending_valid;
  assign ref_dir = commit ? pending_dir : dir;

  assign locked  = (lock_cnt != '0) && (key_byte == last_byte);
  assign accept  = (state == DECODE) && key.valid && !locked;
  assign relock  = (state == DECODE) && key.valid && locked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_byte       <= '0;
      last_byte     <= '0;
      lock_cnt      <= '0;
      pending_dir   <= INIT_DIR;
      pending_valid <= 1'b0;
      dir           <= INIT_DIR;
      pause         <= 1'b0;
      start_pulse   <= 1'b0;
      cmd_strobe    <= 1'b0;
      key_data      <= '0;
    end else begin
      cmd_strobe  <= accept;
      start_pulse <= accept && key.enter;

      if (state == POP && !rx_empty) rx_byte <= r_data;

      if (accept || relock)     lock_cnt <= LOCK_LOAD;
      else if (lock_cnt != '0)  lock_cnt <= lock_cnt - LW'(1);

      if (commit) begin
        dir           <= pending_dir;
        pending_valid <= 1'b0;
      end

      if (accept) begin
        key_data  <= key_byte;
        last_byte <= key_byte;
        if (key.is_dir && (key.dir != (ref_dir ^ 2'd2))) begin
          pending_dir   <= key.dir;
          pending_valid <= 1'b1;
        end
        if (key.space) pause <= ~pause;
        if (key.enter) pause <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_controller.sv
module tb_uart_cmd_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       game_tick;
  logic       rd_uart;
  logic [1:0] dir;
  logic       pause;
  logic       start_pulse;
  logic       cmd_strobe;
  logic [7:0] key_data;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] q[$];
  int  cyc = 0;
  int  last_pop = -100;
  logic pop_due = 1'b0;
  int  pop_cnt = 0;
  int  rd_viol = 0;
  int  strobe_cnt = 0;
  int  start_cnt = 0;

  uart_cmd_controller #(.LOCK_CYCLES(10), .INIT_DIR(2'd1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .r_data(r_data),
    .game_tick(game_tick), .rd_uart(rd_uart), .dir(dir), .pause(pause),
    .start_pulse(start_pulse), .cmd_strobe(cmd_strobe), .key_data(key_data)
  );

  always #5 clk = ~clk;

  // FIFO model and output monitors, all on the falling edge.
  always @(negedge clk) begin
    logic do_pop;
    cyc++;
    do_pop = pop_due;
    pop_due = 1'b0;
    if (rd_uart) begin
      pop_cnt++;
      if (rx_empty) rd_viol++;
      if (cyc - last_pop < 3) rd_viol++;
      last_pop = cyc;
      pop_due = 1'b1;
    end
    if (do_pop && q.size() > 0) void'(q.pop_front());
    rx_empty = (q.size() == 0);
    r_data   = (q.size() > 0) ? q[0] : 8'h00;
    if (cmd_strobe)  strobe_cnt++;
    if (start_pulse) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    #1 q.push_back(b);
  endtask

  task automatic tick();
    @(negedge clk);
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    idle(2);
  endtask

  initial begin
    int s0;
    logic seen;
    rst_n = 1'b0;
    game_tick = 1'b0;
    idle(3);
    chk("rst_dir", dir, 2'd1);
    chk("rst_pause", pause, 0);
    chk("rst_rd", rd_uart, 0);
    chk("rst_key", key_data, 8'h00);
    chk("rst_strobe", cmd_strobe, 0);
    chk("rst_start", start_pulse, 0);
    rst_n = 1'b1;
    idle(2);

    // 'd','s' back to back, no tick
    push(8'h64); push(8'h73);
    idle(12);
    chk("ds_pops", pop_cnt, 2);
    chk("ds_strobes", strobe_cnt, 2);
    chk("ds_key", key_data, 8'h73);
    chk("ds_dir_hold", dir, 2'd1);
    tick();
    chk("ds_dir_commit", dir, 2'd2);
    tick();
    chk("ds_pend_clear", dir, 2'd2);

    // reversal: 'w' while moving down
    s0 = strobe_cnt;
    push(8'h77);
    idle(8);
    chk("rev_strobe", strobe_cnt - s0, 1);
    chk("rev_key", key_data, 8'h77);
    tick();
    chk("rev_dir", dir, 2'd2);
    idle(20);

    // unrecognised byte
    s0 = strobe_cnt;
    push(8'h78);
    idle(8);
    chk("junk_strobe", strobe_cnt - s0, 0);
    chk("junk_key", key_data, 8'h77);

    // lockout: repeated 'w'
    s0 = strobe_cnt;
    push(8'h77); push(8'h77);
    idle(10);
    chk("lock_one", strobe_cnt - s0, 1);
    idle(20);
    push(8'h77);
    idle(8);
    chk("lock_expired", strobe_cnt - s0, 2);

    // pause, pending held through paused tick, then Enter
    push(8'h20);
    idle(8);
    chk("pause_on", pause, 1);
    push(8'h64);
    idle(8);
    tick();
    chk("pause_tick_dir", dir, 2'd2);
    chk("pause_still", pause, 1);
    push(8'h0D);
    idle(8);
    chk("start_cnt", start_cnt, 1);
    chk("enter_unpause", pause, 0);
    tick();
    chk("resume_dir", dir, 2'd1);

    // later key overwrites earlier pending
    push(8'h73); push(8'h77);
    idle(12);
    tick();
    chk("overwrite_dir", dir, 2'd0);

    // DECODE coincident with tick: commit down, then 'w' is a reversal
    push(8'h64);
    idle(8);
    tick();
    chk("pre_right", dir, 2'd1);
    push(8'h73);
    idle(8);
    s0 = strobe_cnt;
    push(8'h77);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    game_tick = 1'b1;
    @(negedge clk);
    game_tick = 1'b0;
    idle(4);
    chk("coinc_dir", dir, 2'd2);
    chk("coinc_strobe", strobe_cnt - s0, 1);
    chk("coinc_key", key_data, 8'h77);
    tick();
    chk("coinc_dropped", dir, 2'd2);

    // ESC then 'A'
    push(8'h1B); push(8'h41);
    idle(12);
    tick();
`ifdef UART_CMD_ANSI_ARROWS_EN
    chk("esc_a_key", key_data, 8'h77);
    chk("esc_a_dir", dir, 2'd2);
`else
    chk("esc_a_key", key_data, 8'h41);
    chk("esc_a_dir", dir, 2'd3);
`endif
    idle(20);

    // ESC [ D: left arrow with the macro, plain 'D' (a reversal of left) without
    push(8'h1B); push(8'h5B); push(8'h44);
    idle(15);
    tick();
    chk("arrow_key", key_data, 8'h44);
    chk("arrow_dir", dir, 2'd3);

    chk("rd_spacing", rd_viol, 0);
    chk("start_total", start_cnt, 1);

    // reset while the pop strobe is high
    s0 = strobe_cnt;
    push(8'h61);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = rd_uart;
    end
    chk("mid_rd_seen", seen, 1);
    #1 rst_n = 1'b0;
    #1 chk("mid_rd_drop", rd_uart, 0);
    idle(3);
    rst_n = 1'b1;
    idle(8);
    chk("mid_no_strobe", strobe_cnt - s0, 0);
    chk("mid_key", key_data, 8'h00);
    chk("mid_dir", dir, 2'd1);
    chk("mid_fifo_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
